// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// alarm_pkg -- shared types, 50 MHz timing defaults and counter-width helper
// Revision: 1.0
// ============================================================================
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_HOLD     = 2'd2
    } btn_state_e;

    // Defaults at 50 MHz: 20 ms debounce, 500 ms first repeat, 100 ms repeat period
    localparam int c_debounce_cycles      = 1_000_000;
    localparam int c_repeat_delay_cycles  = 25_000_000;
    localparam int c_repeat_period_cycles = 5_000_000;

    // Bits needed to count 0..max_count-1, never narrower than one bit
    function automatic int cnt_width(input int max_count);
        return (max_count <= 2) ? 1 : $clog2(max_count);
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
// button_channel -- synchroniser, debounce, hold/repeat FSM for one button
// Revision: 1.0
// ============================================================================
module button_channel
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = c_debounce_cycles,
    parameter int REPEAT_DELAY_CYCLES  = c_repeat_delay_cycles,
    parameter int REPEAT_PERIOD_CYCLES = c_repeat_period_cycles,
    parameter bit REPEAT_EN            = 1'b1,
    parameter bit ACTIVE_LOW_IN        = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int c_dcnt_w   = cnt_width(DEBOUNCE_CYCLES);
    localparam int c_hold_max = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int c_hold_w   = cnt_width(c_hold_max);

    localparam logic [c_dcnt_w-1:0] c_dcnt_last  = c_dcnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_dcnt_w-1:0] c_dcnt_one   = c_dcnt_w'(1);
    localparam logic [c_hold_w-1:0] c_delay_last = c_hold_w'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_per_last   = c_hold_w'(REPEAT_PERIOD_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_one   = c_hold_w'(1);

    logic                sync1_q,   sync1_d;
    logic                sync2_q,   sync2_d;
    logic [c_dcnt_w-1:0] dcnt_q,    dcnt_d;
    logic                level_q,   level_d;
    btn_state_e          state_q,   state_d;
    logic [c_hold_w-1:0] hold_q,    hold_d;
    logic                press_q,   press_d;
    logic                release_q, release_d;
    logic                repeat_q,  repeat_d;

    logic w_s;
    logic w_rise;
    logic w_fall;

    // Synchroniser and debounce: level follows s only after an unbroken run of disagreement
    always_comb begin
        sync1_d = i_raw;
        sync2_d = sync1_q;
        w_s     = ACTIVE_LOW_IN ? ~sync2_q : sync2_q;
        level_d = level_q;
        dcnt_d  = '0;
        if (w_s != level_q) begin
            if (dcnt_q == c_dcnt_last) begin
                level_d = w_s;
            end else begin
                dcnt_d = dcnt_q + c_dcnt_one;
            end
        end
    end

    // Strobes are registered alongside the level, so they look one step ahead at level_d
    assign w_rise = level_d & ~level_q;
    assign w_fall = ~level_d & level_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                hold_d = '0;
                if (w_rise) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (w_fall) begin
                    state_d   = ST_RELEASED;
                    release_d = 1'b1;
                    hold_d    = '0;
                end else if (!REPEAT_EN) begin
                    hold_d = '0;
                end else if (hold_q == c_delay_last) begin
                    state_d  = ST_HOLD;
                    repeat_d = 1'b1;
                    hold_d   = '0;
                end else begin
                    hold_d = hold_q + c_hold_one;
                end
            end
            ST_HOLD: begin
                // Release wins over a coincident repeat terminal count
                if (w_fall) begin
                    state_d   = ST_RELEASED;
                    release_d = 1'b1;
                    hold_d    = '0;
                end else if (hold_q == c_per_last) begin
                    repeat_d = 1'b1;
                    hold_d   = '0;
                end else begin
                    hold_d = hold_q + c_hold_one;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Synchroniser resets to the pin's idle level so s reads "not pressed"
            sync1_q   <= ACTIVE_LOW_IN;
            sync2_q   <= ACTIVE_LOW_IN;
            dcnt_q    <= '0;
            level_q   <= 1'b0;
            state_q   <= ST_RELEASED;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            dcnt_q    <= dcnt_d;
            level_q   <= level_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_repeat  = repeat_q;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// button_conditioner -- per-button debounce plus press/release/repeat strobes
// Revision: 1.0
// ============================================================================
module button_conditioner
    import alarm_pkg::*;
#(
    parameter int                   N_BUTTONS            = 2,
    parameter int                   DEBOUNCE_CYCLES      = c_debounce_cycles,
    parameter int                   REPEAT_DELAY_CYCLES  = c_repeat_delay_cycles,
    parameter int                   REPEAT_PERIOD_CYCLES = c_repeat_period_cycles,
    parameter logic [N_BUTTONS-1:0] REPEAT_EN            = {N_BUTTONS{1'b1}},
    parameter bit                   ACTIVE_LOW_IN        = 1'b1
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [N_BUTTONS-1:0] btn_raw_i,
    output logic [N_BUTTONS-1:0] btn_level_o,
    output logic [N_BUTTONS-1:0] btn_press_o,
    output logic [N_BUTTONS-1:0] btn_release_o,
    output logic [N_BUTTONS-1:0] btn_repeat_o
);

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
            .REPEAT_EN            (REPEAT_EN[g]),
            .ACTIVE_LOW_IN        (ACTIVE_LOW_IN)
        ) u_channel (
            .clk       (clk_clk),
            .rst_n     (reset_reset_n),
            .i_raw     (btn_raw_i[g]),
            .o_level   (btn_level_o[g]),
            .o_press   (btn_press_o[g]),
            .o_release (btn_release_o[g]),
            .o_repeat  (btn_repeat_o[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// tb_button_conditioner -- directed and random stimulus against a timing model
// Revision: 1.0
// ============================================================================
module tb_button_conditioner;

    localparam int         N       = 2;
    localparam int         DEB     = 4;
    localparam int         DLY     = 20;
    localparam int         PER     = 8;
    localparam logic [1:0] EN_MASK = 2'b01;
    localparam bit         ACT_LOW = 1'b1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] raw   = 2'b11;
    logic [1:0] level, press, rel, rpt;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BUTTONS            (N),
        .DEBOUNCE_CYCLES      (DEB),
        .REPEAT_DELAY_CYCLES  (DLY),
        .REPEAT_PERIOD_CYCLES (PER),
        .REPEAT_EN            (EN_MASK),
        .ACTIVE_LOW_IN        (ACT_LOW)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .btn_raw_i     (raw),
        .btn_level_o   (level),
        .btn_press_o   (press),
        .btn_release_o (rel),
        .btn_repeat_o  (rpt)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: pressed samples delayed two edges, level flips after DEB straight disagreeing
    // samples, repeats fall on press + DLY + k*PER while the level stays high.
    logic [1:0] en_v = EN_MASK;
    bit m_level[N];
    bit m_press[N];
    bit m_rel[N];
    bit m_rpt[N];
    bit m_p1[N];
    bit m_p2[N];
    int m_press_cyc[N];
    bit m_win[N][$];

    int press_log[N][$];
    int rel_log[N][$];
    int rpt_log[N][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit s;
        bit old;
        bit all_diff;
        int age;
        for (int c = 0; c < N; c++) begin
            if (!rst_n) begin
                m_p1[c] = 1'b0;
                m_p2[c] = 1'b0;
                m_level[c] = 1'b0;
                m_press[c] = 1'b0;
                m_rel[c] = 1'b0;
                m_rpt[c] = 1'b0;
                m_win[c].delete();
            end else begin
                s = m_p2[c];
                m_p2[c] = m_p1[c];
                m_p1[c] = ACT_LOW ? ~raw[c] : raw[c];
                old = m_level[c];
                m_win[c].push_back(s);
                if (m_win[c].size() > DEB) void'(m_win[c].pop_front());
                all_diff = (m_win[c].size() == DEB);
                for (int k = 0; k < m_win[c].size(); k++)
                    if (m_win[c][k] == old) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[c] = ~old;
                    m_win[c].delete();
                end
                m_press[c] = m_level[c] & ~old;
                m_rel[c]   = ~m_level[c] & old;
                if (m_press[c]) m_press_cyc[c] = cyc;
                age = cyc - m_press_cyc[c];
                m_rpt[c] = old && m_level[c] && en_v[c] && (age >= DLY) && (((age - DLY) % PER) == 0);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("level",   level, {30'd0, m_level[1], m_level[0]});
        chk("press",   press, {30'd0, m_press[1], m_press[0]});
        chk("release", rel,   {30'd0, m_rel[1],   m_rel[0]});
        chk("repeat",  rpt,   {30'd0, m_rpt[1],   m_rpt[0]});
        for (int c = 0; c < N; c++) begin
            if (press[c] === 1'b1) press_log[c].push_back(cyc);
            if (rel[c] === 1'b1)   rel_log[c].push_back(cyc);
            if (rpt[c] === 1'b1)   rpt_log[c].push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        for (int c = 0; c < N; c++) begin
            press_log[c].delete();
            rel_log[c].delete();
            rpt_log[c].delete();
        end
    endtask

    initial begin
        int t;
        int r0;
        int dur;

        // Reset with btn0 held pressed; press emerges 6 cycles after the last reset edge
        raw = 2'b10;
        tick(3);
        rst_n = 1'b1;
        r0 = cyc;
        tick(5);
        chk("lvl0_before_press", level[0], 0);
        chk("press0_before", press[0], 0);
        tick(1);
        chk("press0_at_6", press[0], 1);
        chk("lvl0_at_6", level[0], 1);
        chk("press0_cycle", (press_log[0].size() > 0) ? press_log[0][0] : -1, r0 + 6);
        tick(1);
        chk("press0_one_cycle", press[0], 0);
        raw = 2'b11;
        tick(12);

        // Short glitch is ignored
        clear_logs();
        raw[0] = 1'b0;
        tick(3);
        raw[0] = 1'b1;
        tick(12);
        chk("glitch_press", press_log[0].size(), 0);
        chk("glitch_release", rel_log[0].size(), 0);
        chk("glitch_level", level[0], 0);

        // Long hold: press, five repeats, release collides with the next repeat slot
        clear_logs();
        t = cyc;
        raw[0] = 1'b0;
        tick(60);
        raw[0] = 1'b1;
        tick(15);
        chk("hold_press_n", press_log[0].size(), 1);
        chk("hold_press_t", (press_log[0].size() > 0) ? press_log[0][0] : -1, t + 6);
        chk("hold_rpt_n", rpt_log[0].size(), 5);
        for (int k = 0; k < 5; k++)
            chk("hold_rpt_t", (rpt_log[0].size() > k) ? rpt_log[0][k] : -1, t + 26 + 8 * k);
        chk("hold_rel_n", rel_log[0].size(), 1);
        chk("hold_rel_t", (rel_log[0].size() > 0) ? rel_log[0][0] : -1, t + 66);

        // Bouncing btn1 settles low: one press after the final edge, no repeats (masked)
        clear_logs();
        t = cyc;
        for (int k = 0; k < 5; k++) begin
            raw[1] = k[0];
            tick(2);
        end
        tick(30);
        chk("bounce_press_n", press_log[1].size(), 1);
        chk("bounce_press_t", (press_log[1].size() > 0) ? press_log[1][0] : -1, t + 14);
        chk("bounce_no_rpt", rpt_log[1].size(), 0);
        raw[1] = 1'b1;
        tick(12);

        // Both pressed together for 40 cycles
        clear_logs();
        t = cyc;
        raw = 2'b00;
        tick(40);
        raw = 2'b11;
        tick(12);
        chk("both_press0", (press_log[0].size() > 0) ? press_log[0][0] : -1, t + 6);
        chk("both_press1", (press_log[1].size() > 0) ? press_log[1][0] : -1, t + 6);
        chk("both_rpt0_n", rpt_log[0].size(), 3);
        chk("both_rpt1_n", rpt_log[1].size(), 0);
        chk("both_rel0", (rel_log[0].size() > 0) ? rel_log[0][0] : -1, t + 46);
        chk("both_rel1", (rel_log[1].size() > 0) ? rel_log[1][0] : -1, t + 46);

        // Reset while repeating: silent clear, then fresh press 6 cycles later
        clear_logs();
        raw[0] = 1'b0;
        tick(30);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        r0 = cyc;
        chk("rst_level", level, 0);
        chk("rst_press", press, 0);
        chk("rst_release", rel, 0);
        chk("rst_repeat", rpt, 0);
        tick(6);
        chk("rst_fresh_press", press[0], 1);
        chk("rst_no_release", rel_log[0].size(), 0);
        tick(30);
        raw[0] = 1'b1;
        tick(12);
        chk("rst_press_n", press_log[0].size(), 2);
        chk("rst_press_t", (press_log[0].size() > 1) ? press_log[0][1] : -1, r0 + 6);
        chk("rst_rel_n", rel_log[0].size(), 1);

        // Random segments, mixing glitches, long holds and occasional resets
        for (int seg = 0; seg < 150; seg++) begin
            raw = 2'($urandom_range(0, 3));
            dur = $urandom_range(1, 30);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
            tick(dur);
        end
        raw = 2'b11;
        tick(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
